// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types: image geometry, pixel/image typedefs, loader states.
package cnn_pkg;

    localparam int unsigned IMG_DIM = 28;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RC_W    = $clog2(IMG_DIM);

    typedef logic [DATA_W-1:0] pix_t;
    typedef pix_t [0:IMG_DIM-1][0:IMG_DIM-1] image_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major row/col counter pair with wrap and clear.
//   clk, resetn : clock, async active-low reset
//   adv         : advance one position (col first, row on col wrap)
//   clr         : return to (0,0); dominates adv
//   row, col    : current position (registered)
//   last_c      : current position is (DIM-1, DIM-1)
module raster_counter #(
    parameter int unsigned DIM = 28,
    parameter int unsigned W   = $clog2(DIM)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         adv,
    input  logic         clr,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         last_c
);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    // Compare-and-wrap stepping, no arithmetic beyond +1.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == W'(DIM - 1)) begin
                col_d = '0;
                row_d = (row_q == W'(DIM - 1)) ? '0 : row_q + W'(1);
            end else begin
                col_d = col_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row    = row_q;
    assign col    = col_q;
    assign last_c = (row_q == W'(DIM - 1)) && (col_q == W'(DIM - 1));

endmodule

// File: rtl/pic_stream_loader.sv
// Assembles a row-major fp32 pixel stream into the parallel image for conv_1,
// raises start_flag on a full frame and holds it until the pipeline handoff.
//   s_valid/s_data/s_last/s_ready : pixel word stream in
//   pic_out     : assembled image (frozen while busy)
//   start_flag  : pipeline start level, high from START until handoff rise
//   handoff_in  : final pipeline handoff; only a fresh rise in WAIT_DONE counts
//   busy        : loader not accepting (START or WAIT_DONE)
//   frame_err   : one-cycle pulse on early or missing s_last
//   frame_cnt   : frames completed through WAIT_DONE (wrapping)
module pic_stream_loader
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output image_t           pic_out,
    output logic             start_flag,
    input  logic             handoff_in,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    loader_state_t    state_q, state_d;
    image_t           pic_q, pic_d;
    logic             s_ready_q, s_ready_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             handoff_q;

    logic [RC_W-1:0]  row, col;
    logic             pos_last_c;
    logic             xfer_c;
    logic             cnt_clr_c;
    logic             handoff_rise_c;

    assign xfer_c         = s_valid && s_ready_q && (state_q == FILL);
    assign handoff_rise_c = handoff_in && !handoff_q;
    // Any frame end (good or early) and any non-FILL state parks the raster at 0.
    assign cnt_clr_c      = (state_q != FILL) || (xfer_c && (s_last || pos_last_c));

    raster_counter #(
        .DIM (IMG_DIM),
        .W   (RC_W)
    ) u_raster (
        .clk    (clk),
        .resetn (resetn),
        .adv    (xfer_c),
        .clr    (cnt_clr_c),
        .row    (row),
        .col    (col),
        .last_c (pos_last_c)
    );

    // Next-state, pixel write and registered-output decode.
    always_comb begin
        state_d     = state_q;
        pic_d       = pic_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (xfer_c) begin
            pic_d[row][col] = s_data;
        end

        unique case (state_q)
            FILL: begin
                if (xfer_c) begin
                    if (pos_last_c) begin
                        state_d     = START;
                        frame_err_d = !s_last;
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (handoff_rise_c) begin
                    state_d     = FILL;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        s_ready_d = (state_d == FILL);
        start_d   = (state_d != FILL);
        busy_d    = (state_d != FILL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= FILL;
            pic_q       <= '0;
            s_ready_q   <= 1'b1;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            handoff_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pic_q       <= pic_d;
            s_ready_q   <= s_ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            handoff_q   <= handoff_in;
        end
    end

    assign s_ready    = s_ready_q;
    assign pic_out    = pic_q;
    assign start_flag = start_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pic_stream_loader.sv
// Bench for pic_stream_loader: hand-written vector table, directed frame
// sequences and randomized traffic against a flat-index reference model.
module tb_pic_stream_loader;
    import cnn_pkg::*;

    localparam int NPIX     = IMG_DIM * IMG_DIM;
    localparam int PH_FILL  = 0;
    localparam int PH_START = 1;
    localparam int PH_WAIT  = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             s_valid = 1'b0;
    logic [31:0]      s_data = '0;
    logic             s_last = 1'b0;
    logic             s_ready;
    image_t           pic_out;
    logic             start_flag;
    logic             handoff_in = 1'b0;
    logic             busy;
    logic             frame_err;
    logic [7:0]       frame_cnt;

    pic_stream_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .pic_out    (pic_out),
        .start_flag (start_flag),
        .handoff_in (handoff_in),
        .busy       (busy),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;

    // Reference model: flat pixel list, next index, phase, frame count.
    logic [31:0] m_img [NPIX];
    int          m_idx;
    int          m_phase;
    int          m_cnt;
    logic        m_err;
    logic        m_hprev;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        h;
        logic        e_rdy;
        logic        e_start;
        logic        e_err;
    } vec_t;
    vec_t tbl [8];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NPIX; i++) m_img[i] = '0;
        m_idx = 0; m_phase = PH_FILL; m_cnt = 0; m_err = 1'b0; m_hprev = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [31:0] d, input logic l, input logic h);
        m_err = 1'b0;
        case (m_phase)
            PH_FILL: if (v) begin
                m_img[m_idx] = d;
                if (m_idx == NPIX - 1) begin
                    m_phase = PH_START; m_err = !l; m_idx = 0;
                end else if (l) begin
                    m_err = 1'b1; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            PH_START: m_phase = PH_WAIT;
            default: if (h && !m_hprev) begin
                m_phase = PH_FILL; m_cnt = (m_cnt + 1) % 256;
            end
        endcase
        m_hprev = h;
    endfunction

    function automatic void compare_img(input string name);
        int bad = -1;
        for (int i = 0; i < NPIX; i++)
            if (bad < 0 && pic_out[i / IMG_DIM][i % IMG_DIM] !== m_img[i]) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: pixel %0d got %h expected %h", name, bad,
                     pic_out[bad / IMG_DIM][bad % IMG_DIM], m_img[bad]);
        end
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic h);
        s_valid = v; s_data = d; s_last = l; handoff_in = h;
        @(posedge clk);
        model_step(v, d, l, h);
        #1;
        chk("s_ready",    32'(s_ready),    32'(m_phase == PH_FILL));
        chk("start_flag", 32'(start_flag), 32'(m_phase != PH_FILL));
        chk("busy",       32'(busy),       32'(m_phase != PH_FILL));
        chk("frame_err",  32'(frame_err),  32'(m_err));
        chk("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
        if (frame_err) err_seen++;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, then releases.
    task automatic do_reset();
        #2;
        s_valid = 1'b0; s_last = 1'b0; handoff_in = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_start", 32'(start_flag), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_err",   32'(frame_err),  32'd0);
        chk("rst_cnt",   32'(frame_cnt),  32'd0);
        compare_img("rst_pic");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1 chk("rst_ready", 32'(s_ready), 32'd1);
    endtask

    // pattern: 0 = index, 1 = 1.0f, 2 = random. gappy inserts an idle cycle before each word.
    task automatic send_words(input int n, input int pattern, input int last_at, input bit gappy);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            if (gappy) cycle(1'b0, $urandom, 1'b0, 1'b0);
            d = (pattern == 0) ? 32'(k) : (pattern == 1) ? 32'h3F80_0000 : $urandom;
            cycle(1'b1, d, 1'(k == last_at), 1'b0);
        end
    endtask

    task automatic release_frame();
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic void check_index_image(input string name);
        int bad = -1;
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                if (bad < 0 && pic_out[r][c] !== 32'(28 * r + c)) bad = 28 * r + c;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: pixel %0d got %h expected %h", name, bad,
                     pic_out[bad / IMG_DIM][bad % IMG_DIM], bad);
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Table: early s_last, ignored handoff in FILL, restart at index 0.
        tbl[0] = '{1'b1, 32'h0000_00A0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_00A1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_00C0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_00C1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 32'h0000_00E0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].h);
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready),    32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_start", i), 32'(start_flag), 32'(tbl[i].e_start));
            chk($sformatf("tbl%0d_err", i),   32'(frame_err),  32'(tbl[i].e_err));
        end
        chk("tbl_pic00", pic_out[0][0], 32'h0000_00E0);
        chk("tbl_pic01", pic_out[0][1], 32'h0000_00C1);
        chk("tbl_pic02", pic_out[0][2], 32'h0000_0000);
        do_reset();

        // Clean frame with index data.
        err_seen = 0;
        send_words(NPIX, 0, NPIX - 1, 1'b0);
        chk("f1_start", 32'(start_flag), 32'd1);
        chk("f1_ready", 32'(s_ready),    32'd0);
        check_index_image("f1_pic");
        compare_img("f1_model");
        release_frame();
        chk("f1_noerr", 32'(err_seen), 32'd0);

        // Same frame with valid toggling.
        send_words(NPIX, 0, NPIX - 1, 1'b1);
        chk("f2_start", 32'(start_flag), 32'd1);
        check_index_image("f2_pic");
        release_frame();

        // Early s_last at word 100, then a clean constant frame.
        err_seen = 0;
        send_words(101, 2, 100, 1'b0);
        chk("f3_err_once", 32'(err_seen), 32'd1);
        send_words(NPIX, 1, NPIX - 1, 1'b0);
        chk("f3_pic00", pic_out[0][0], 32'h3F80_0000);
        chk("f3_errs", 32'(err_seen), 32'd1);
        compare_img("f3_model");
        release_frame();

        // Handoff already high from START: only a fresh rise releases.
        do_reset();
        send_words(NPIX, 2, NPIX - 1, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("f4_hold_start", 32'(start_flag), 32'd1);
        chk("f4_hold_cnt",   32'(frame_cnt),  32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("f4_rel_start", 32'(start_flag), 32'd0);
        chk("f4_rel_ready", 32'(s_ready),    32'd1);
        chk("f4_rel_cnt",   32'(frame_cnt),  32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Full frame without s_last.
        err_seen = 0;
        send_words(NPIX, 0, -1, 1'b0);
        chk("f5_start", 32'(start_flag), 32'd1);
        chk("f5_err_once", 32'(err_seen), 32'd1);
        check_index_image("f5_pic");

        // Reset in WAIT_DONE, then at word 400, then reload.
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        send_words(400, 2, -1, 1'b0);
        do_reset();
        send_words(NPIX, 0, NPIX - 1, 1'b0);
        check_index_image("f6_pic");
        release_frame();

        // Randomized traffic.
        h = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 5) == 0) h = ~h;
            cycle(1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 299) == 0), h);
            if (m_phase == PH_START) compare_img("rnd_pic");
        end
        compare_img("rnd_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pic_stream_loader.md
Name: pic_stream_loader

Overview:
- Upstream feeder for the CNN pipeline (conv_1 -> conv_2 -> meanMod -> linLay -> argmax).
- Accepts one 28x28 image as a valid/ready stream of fp32 pixel words, row-major, and assembles it into the parallel pixel array that drives conv_1's `in`.
- Raises the pipeline start flag when a full frame is loaded.
- Holds the array stable and back-pressures the stream until the pipeline's final handoff rises.

Parameters:
- IMG_DIM, 28, image height and width in pixels.
- DATA_W, 32, pixel word width (IEEE-754 single, passed through unmodified).
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  pixel word, row-major order, index = row*IMG_DIM+col.
- s_last  in  1  marks the final word of a frame.
- s_ready  out  1  loader can accept a word.
- pic_out  out  DATA_W x [0:IMG_DIM-1][0:IMG_DIM-1]  assembled image; drives conv_1 `in`.
- start_flag  out  1  pipeline start; drives conv_1 startFlag.
- handoff_in  in  1  final pipeline handoff (handOff from top level).
- busy  out  1  high in START or WAIT_DONE.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  CNT_W  count of frames completed through WAIT_DONE.

Behaviour:
- Reset (async, resetn=0):
  - State = FILL; row/col counters = 0.
  - Every pic_out element = 0.
  - start_flag=0, frame_err=0, frame_cnt=0.
  - Internal handoff_in delay register = 0.
  - s_ready=1 as soon as resetn deasserts.
  - Reset mid-frame or mid-inference discards all progress; no start_flag is issued for the partial frame.
- State FILL:
  - s_ready=1.
  - A transfer occurs when s_valid & s_ready on a rising clk.
  - The word is written to pic_out[row][col].
  - col increments; when col wraps IMG_DIM-1 -> 0, row increments.
  - Counters use compare-and-wrap only; no multiply or divide.
- Early s_last (s_last=1 on a word whose index < IMG_DIM*IMG_DIM-1):
  - The word is written.
  - frame_err pulses next cycle.
  - row/col are cleared to 0 and the state stays FILL; the partial frame is abandoned.
  - Already-written pic_out elements are not cleared.
- Final word (index IMG_DIM*IMG_DIM-1, i.e. 783):
  - The word is written and the state goes to START next cycle, regardless of s_last.
  - If s_last=0 on this word, frame_err pulses the same cycle START is entered; the frame is still accepted.
- State START:
  - s_ready=0, start_flag=1.
  - Lasts exactly 1 cycle, then goes to WAIT_DONE.
- State WAIT_DONE:
  - s_ready=0; start_flag stays 1, so downstream sees a level and a rising edge.
  - pic_out is frozen.
  - On a rising edge of handoff_in (handoff_in=1 and delayed copy=0):
    - start_flag drops next cycle.
    - frame_cnt increments, wrapping at 2^CNT_W.
    - State returns to FILL with row/col=0; s_ready=1 that same cycle.
- Latency: final word accepted at cycle N -> start_flag=1 at N+1 -> s_ready=1 at H+1, where H is the cycle in which the handoff_in edge is sampled.
- handoff_in level or edges in FILL or START are ignored; only the delay register updates.
- A handoff_in already high on entry to WAIT_DONE is not an edge. The loader waits for a fresh low->high transition.
- s_data is passed through bit-exact; the loader does no arithmetic on pixels.
- busy = (state != FILL).

Decomposition:
- Shared package cnn_pkg:
  - IMG_DIM and DATA_W constants.
  - typedef pix_t (logic [DATA_W-1:0]).
  - typedef image_t (pix_t [0:IMG_DIM-1][0:IMG_DIM-1]).
  - Enum loader_state_t {FILL, START, WAIT_DONE}.
- One natural sub-module: raster_counter, holding the row/col counter pair with wrap, clear, and a last-index flag. It is reusable later by a weight loader.

Test Plan:
- Reset, then stream 784 words with s_data=index and s_last on word 783 -> pic_out[r][c]=28r+c; start_flag=1 exactly one cycle after word 783; s_ready=0; frame_err never pulses.
- Same frame with s_valid toggling every other cycle -> identical pic_out; start_flag one cycle after the 784th accepted word.
- s_last on word 100 -> frame_err pulse; s_ready stays 1. Next 784 words (s_data=0x3F800000) load and start cleanly; pic_out[0][0]=0x3F800000.
- Full frame, then handoff_in held high 5 cycles from the START cycle, then low, then high -> start_flag stays high until the second rise; frame_cnt 0->1; s_ready=1 on the following cycle.
- 784 words with no s_last -> frame accepted; start_flag asserted; frame_err pulses once.
- Assert resetn=0 during WAIT_DONE and again at word 400 of a frame -> all outputs return to reset values immediately (async); the following frame loads from index 0.
